// File: rtl/tlc_phase_scheduler_if.sv
// Signal bundle between the intersection controller core and its driver.
// The master drives the time base and sensors; the slave returns the lamps.
interface tlc_phase_scheduler_if;
  logic       tick;
  logic [3:0] req;
  logic       ped_req;
  logic [3:0] green;
  logic [3:0] yellow;
  logic       ped_walk;
  logic [1:0] phase_id;
  logic       ped_pending;

  modport master (
    output tick, req, ped_req,
    input  green, yellow, ped_walk, phase_id, ped_pending
  );

  modport slave (
    input  tick, req, ped_req,
    output green, yellow, ped_walk, phase_id, ped_pending
  );
endinterface

// File: rtl/tlc_phase_scheduler.sv
// Four-approach round-robin green scheduler with yellow/all-red clearance
// and a latched pedestrian walk phase; all timing advances on the tick strobe.
module tlc_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6,
  parameter int CNT_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tlc_phase_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {S_ALL_RED, S_GREEN, S_YELLOW, S_WALK} state_t;

  localparam logic [CNT_W-1:0] MIN_C       = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_C       = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] ALLRED_C    = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [1:0]       phase, phase_nxt;
  logic             ped_pend, ped_nxt;
  logic [3:0]       green_q, yellow_q, green_nxt, yellow_nxt;
  logic             walk_q, walk_nxt;

  logic [3:0]       own_mask;
  logic             demand;
  logic             allred_done;
  logic [CNT_W-1:0] grn_cnt;
  logic             rr_hit;
  logic [1:0]       rr_idx;

  // Green count including the current tick; it parks at MAX_GREEN while resting.
  assign grn_cnt     = (bus.tick && (timer < MAX_C)) ? timer + 1'b1 : timer;
  assign own_mask    = 4'b0001 << phase;
  assign demand      = ped_pend | (|(bus.req & ~own_mask));
  assign allred_done = (timer >= ALLRED_C) | (bus.tick & (timer == ALLRED_LAST));

  // First requesting approach after the last one served, wrapping back to itself.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = phase;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[phase + 2'(k)]) begin
        rr_hit = 1'b1;
        rr_idx = phase + 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_ALL_RED;
      timer    <= '0;
      phase    <= 2'd3;
      ped_pend <= 1'b0;
      green_q  <= '0;
      yellow_q <= '0;
      walk_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      phase    <= phase_nxt;
      ped_pend <= ped_nxt;
      green_q  <= green_nxt;
      yellow_q <= yellow_nxt;
      walk_q   <= walk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    ped_nxt   = ped_pend | (bus.ped_req & (state != S_WALK));
    unique case (state)
      S_ALL_RED: begin
        if (allred_done) begin
          if (ped_pend) begin
            state_nxt = S_WALK;
            ped_nxt   = 1'b0;
          end else if (rr_hit) begin
            state_nxt = S_GREEN;
            phase_nxt = rr_idx;
          end
        end
      end
      S_GREEN:  if (bus.tick && demand && (grn_cnt >= MIN_C)) state_nxt = S_YELLOW;
      S_YELLOW: if (bus.tick && (timer == YEL_LAST))          state_nxt = S_ALL_RED;
      S_WALK:   if (bus.tick && (timer == WALK_LAST))         state_nxt = S_ALL_RED;
      default:  state_nxt = S_ALL_RED;
    endcase

    timer_nxt = timer;
    if (state_nxt != state) timer_nxt = '0;
    else begin
      unique case (state)
        S_ALL_RED: if (bus.tick && (timer < ALLRED_C)) timer_nxt = timer + 1'b1;
        S_GREEN:   timer_nxt = grn_cnt;
        default:   if (bus.tick) timer_nxt = timer + 1'b1;
      endcase
    end
  end

  // Lamps are decoded from the next state so they come straight out of flops.
  always_comb begin
    green_nxt  = '0;
    yellow_nxt = '0;
    walk_nxt   = 1'b0;
    unique case (state_nxt)
      S_GREEN:  green_nxt  = 4'b0001 << phase_nxt;
      S_YELLOW: yellow_nxt = 4'b0001 << phase_nxt;
      S_WALK:   walk_nxt   = 1'b1;
      default:  ;
    endcase
  end

  assign bus.green       = green_q;
  assign bus.yellow      = yellow_q;
  assign bus.ped_walk    = walk_q;
  assign bus.phase_id    = phase;
  assign bus.ped_pending = ped_pend;

  a_one_lamp: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(green_q | yellow_q));
  a_walk_red: assert property (@(posedge clk) disable iff (!rst_n)
    walk_q |-> ((green_q | yellow_q) == 4'b0000));

endmodule
